branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution in the EX stage.
- Takes the decoded branch instr_id with its operands, evaluates the condition, and trains a 2-bit bimodal branch history table (BHT).
- On a misprediction it drives a redirect handshake to fetch, then flushes the wrong-path IF/ID stages.
- Also serves the fetch-stage prediction lookup and keeps branch/mispredict statistics.

Parameters:
- XLEN, 32, datapath and PC width.
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, ≥2. IDX = log2(BHT_ENTRIES).
- FLUSH_CYCLES, 2, cycles the flush output is asserted after the redirect is accepted; ≥1.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_instr_id  in  `INST_ID_LEN  decoded instruction id
- ex_pc  in  XLEN  PC of the EX instruction
- ex_rs1  in  XLEN  operand 1
- ex_rs2  in  XLEN  operand 2
- ex_imm  in  XLEN  sign-extended branch offset
- ex_pred_taken  in  1  prediction fetch made for this instruction
- if_pc  in  XLEN  fetch PC for the prediction lookup
- if_pred_taken  out  1  BHT prediction for if_pc
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  XLEN  corrected PC
- redirect_ready  in  1  fetch accepts the redirect
- flush  out  1  kill IF/ID contents
- stall_ex  out  1  hold EX/ID while a redirect is in progress
- branch_cnt  out  32  resolved branches, wraps
- mispredict_cnt  out  32  mispredictions, wraps

Behaviour:
- Single clock domain. Asynchronous, active-high reset, clock clk, reset rst.
- Reset values: state IDLE; redirect_valid=0; redirect_pc=0; flush=0; stall_ex=0; both counters 0; every BHT entry 2'b01 (weakly not-taken).
- Branch detection: branch = ex_valid && ex_instr_id ∈ {`BEQ_ID, `BNE_ID, `BLT_ID, `BGE_ID, `BLTU_ID, `BGEU_ID}. Any other id, including `NONE_ID, is ignored.
- Condition evaluation:
  - BEQ/BNE: equality.
  - BLT/BGE: signed XLEN compare.
  - BLTU/BGEU: unsigned XLEN compare.
- Next PC: if taken, ex_pc+ex_imm; otherwise ex_pc+4. Both are modulo 2^XLEN (wrap, no error).
- BHT index = pc[IDX+1:2]. Aliasing is permitted.
- Prediction lookup: if_pred_taken = BHT[if_pc index][1], combinational. A same-cycle write to the same entry is not bypassed; the lookup returns the old value.
- BHT update: applied exactly once per branch, at the clock edge of the IDLE cycle in which the branch is seen.
  - Taken: saturating increment (max 11).
  - Not taken: saturating decrement (min 00).
- Statistics: branch_cnt increments on every branch resolved in IDLE. mispredict_cnt increments when taken != ex_pred_taken.
- FSM, IDLE:
  - stall_ex=0, flush=0.
  - On a mispredicted branch: latch redirect_pc; go to WAIT_ACK.
  - Correctly predicted branches and non-branches: stay in IDLE.
- FSM, WAIT_ACK:
  - redirect_valid=1, stall_ex=1.
  - redirect_pc is held stable until accepted.
  - On redirect_valid && redirect_ready: load the flush counter with FLUSH_CYCLES; go to FLUSH.
- FSM, FLUSH:
  - flush=1, stall_ex=1, redirect_valid=0.
  - The counter decrements each cycle; leave for IDLE in the cycle the counter equals 1.
  - Result: flush is high for exactly FLUSH_CYCLES consecutive cycles.
- ex_* inputs are ignored outside IDLE. There is no BHT update and no counter change in those states.
- Latency: redirect_valid rises in the cycle after the mispredicted branch appears in EX. If ready is already high, flush starts one cycle after that.
- An asserted rst at any point (including WAIT_ACK or FLUSH) immediately forces all reset values. Any pending redirect is dropped.

Test Plan:
- Reset: pulse rst mid-cycle → outputs 0 immediately. Then if_pc=0x0..0x3C → if_pred_taken=0 for all.
- Taken mispredict: BEQ, pc=0x100, rs1=rs2=5, imm=0x20, pred=0 → next cycle redirect_valid=1, redirect_pc=0x120, stall_ex=1. Hold ready=0 three cycles → PC stable. ready=1 → flush high exactly 2 cycles, then IDLE. mispredict_cnt=1, branch_cnt=1.
- Not-taken mispredict: BNE, pc=0xFFFFFFFC, rs1=rs2, pred=1 → redirect_pc=0x00000000 (wrap).
- Signedness: rs1=0xFFFFFFFF, rs2=1, pred=0. BLT → taken, redirect asserted. BLTU → not taken, no redirect, branch_cnt increments, mispredict_cnt unchanged.
- BHT training: three taken branches at pc 0x40 → if_pc=0x40 predicts 1. One not-taken → still predicts 1 (10). if_pc=0x80 also predicts 1 (alias, index 0).
- Non-branch and reset mid-op: `NONE_ID with ex_valid=1 → no state change, counters unchanged. Assert rst while in WAIT_ACK → redirect_valid=0 and stall_ex=0 at once; BHT back to 01.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: evaluates the branch condition, trains a bimodal BHT,
// and on a misprediction runs a redirect handshake to fetch followed by an IF/ID flush.
`ifndef INST_ID_LEN
`define INST_ID_LEN 6
`endif
`ifndef NONE_ID
`define NONE_ID 6'd0
`endif
`ifndef BEQ_ID
`define BEQ_ID 6'd1
`endif
`ifndef BNE_ID
`define BNE_ID 6'd2
`endif
`ifndef BLT_ID
`define BLT_ID 6'd3
`endif
`ifndef BGE_ID
`define BGE_ID 6'd4
`endif
`ifndef BLTU_ID
`define BLTU_ID 6'd5
`endif
`ifndef BGEU_ID
`define BGEU_ID 6'd6
`endif

module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  logic [`INST_ID_LEN-1:0] ex_instr_id,
  input  logic [XLEN-1:0]         ex_pc,
  input  logic [XLEN-1:0]         ex_rs1,
  input  logic [XLEN-1:0]         ex_rs2,
  input  logic [XLEN-1:0]         ex_imm,
  input  logic                    ex_pred_taken,
  input  logic [XLEN-1:0]         if_pc,
  output logic                    if_pred_taken,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  input  logic                    redirect_ready,
  output logic                    flush,
  output logic                    stall_ex,
  output logic [31:0]             branch_cnt,
  output logic [31:0]             mispredict_cnt,
  output logic [1:0]              dbg_state
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  localparam int CW  = $clog2(FLUSH_CYCLES + 1);

  // Handshake: fetch takes redirect_pc in the cycle where redirect_valid && redirect_ready;
  // redirect_valid stays high and redirect_pc stable until that cycle.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   flush_cnt;
  logic [1:0]      bht [BHT_ENTRIES];

  logic            is_branch;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] next_pc;
  logic [IDX-1:0]  ex_idx;
  logic [IDX-1:0]  if_idx;
  logic            unused_pc_bits;

  assign ex_idx         = ex_pc[IDX+1:2];
  assign if_idx         = if_pc[IDX+1:2];
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX+2], if_pc[1:0]};
  assign if_pred_taken  = bht[if_idx][1];
  assign dbg_state      = state;

  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    case (ex_instr_id)
      `BEQ_ID:  begin is_branch = ex_valid; taken = (ex_rs1 == ex_rs2); end
      `BNE_ID:  begin is_branch = ex_valid; taken = (ex_rs1 != ex_rs2); end
      `BLT_ID:  begin is_branch = ex_valid; taken = ($signed(ex_rs1) <  $signed(ex_rs2)); end
      `BGE_ID:  begin is_branch = ex_valid; taken = ($signed(ex_rs1) >= $signed(ex_rs2)); end
      `BLTU_ID: begin is_branch = ex_valid; taken = (ex_rs1 <  ex_rs2); end
      `BGEU_ID: begin is_branch = ex_valid; taken = (ex_rs1 >= ex_rs2); end
      default:  begin is_branch = 1'b0;     taken = 1'b0; end
    endcase
    next_pc    = taken ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));
    mispredict = is_branch && (taken != ex_pred_taken);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      stall_ex       <= 1'b0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else begin
      case (state)
        IDLE: begin
          if (is_branch) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (taken && bht[ex_idx] != 2'b11)
              bht[ex_idx] <= bht[ex_idx] + 2'b01;
            else if (!taken && bht[ex_idx] != 2'b00)
              bht[ex_idx] <= bht[ex_idx] - 2'b01;
          end
          if (mispredict) begin
            mispredict_cnt <= mispredict_cnt + 32'd1;
            redirect_pc    <= next_pc;
            redirect_valid <= 1'b1;
            stall_ex       <= 1'b1;
            state          <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (redirect_valid && redirect_ready) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b1;
            flush_cnt      <= CW'(FLUSH_CYCLES);
            state          <= FLUSH;
          end
        end
        FLUSH: begin
          // Counter value 1 marks the last flush cycle.
          if (flush_cnt == CW'(1)) begin
            flush    <= 1'b0;
            stall_ex <= 1'b0;
            state    <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
